// File: rtl/ram_sweep_pkg.sv
// ram_sweep_pkg -- shared types and helpers for the ram_sweep memory.
//   state_t    : controller states (ST_IDLE, ST_CLEAR)
//   CNT_PAD    : extra sweep-counter bits on top of ADDR_W, so that a
//                sweep over DEPTH = 2**ADDR_W words cannot wrap
//   PAR_MAX_W  : widest word par_f accepts; narrower words are zero-extended
//                by the caller, which leaves the parity unchanged
//   par_f()    : even-parity bit of a word
package ram_sweep_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Sweep counter width is ADDR_W + CNT_PAD.
  localparam int CNT_PAD   = 1;
  localparam int PAR_MAX_W = 256;

  // The returned bit makes the total number of ones (data plus parity) even.
  function automatic logic par_f(input logic [PAR_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/ram_sweep_array.sv
// ram_sweep_array -- plain synchronous storage array. It has no reset and
// no control logic.
//   clk    : clock
//   we     : write enable; mem[waddr] <= wdata on the rising edge
//   waddr  : write address (AW bits, always < DEPTH)
//   wdata  : write data (W bits)
//   re     : read enable; rdata <= mem[raddr] on the rising edge
//   raddr  : read address (AW bits, always < DEPTH)
//   rdata  : registered read data; holds its value while re=0
module ram_sweep_array #(
  parameter int W     = 16,
  parameter int AW    = 10,
  parameter int DEPTH = 1024
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/ram_sweep.sv
// ram_sweep -- single-port synchronous RAM with a request handshake,
// registered read data and a hardware clear engine. The clear engine fills
// every word with INIT_VALUE, one word per clock. It runs after reset and
// whenever clr is seen while the RAM is idle.
// Optional feature: define RAM_PARITY_EN to store one even-parity bit per
// word. The bit can be corrupted on purpose with perr_inj and is checked on
// every read.
// Ports:
//   clk        : clock; all state changes on the rising edge
//   r          : asynchronous active-low reset
//   clr        : clear request; only acted on while ready=1
//   req        : access request; accepted when req & ready
//   we         : 1=write, 0=read (qualified by req)
//   addr       : word address
//   wdata      : write data
//   perr_inj   : store inverted parity on an accepted write (parity build only)
//   ready      : block idle
//   busy       : clear sweep in progress
//   rvalid     : one-cycle pulse, read data valid
//   rdata      : read data; held until the next rvalid
//   parity_err : pulses with rvalid when the stored parity does not match
module ram_sweep
  import ram_sweep_pkg::*;
#(
  parameter int                DATA_W     = 16,
  parameter int                ADDR_W     = 10,
  parameter int                DEPTH      = 1024,
  parameter logic [DATA_W-1:0] INIT_VALUE = DATA_W'(16'h0001)
) (
  input  logic              clk,
  input  logic              r,
  input  logic              clr,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              perr_inj,
  output logic              ready,
  output logic              busy,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              parity_err
);

  localparam int CNT_W = ADDR_W + CNT_PAD;
`ifdef RAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               rvalid_reg;
  // Forces rdata to zero. It is set by reset and by out-of-range reads, and
  // cleared by in-range reads. The array read register has no reset, so this
  // flag is what makes rdata read as zero during reset.
  logic               zero_reg;

  logic               in_range, accept, acc_wr, acc_rd;
  logic               mem_we, mem_re;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [MEM_W-1:0]   mem_wdata, mem_rdata, init_word, wr_word;

  assign in_range = ({1'b0, addr} < CNT_W'(DEPTH));
  assign accept   = (state_reg == ST_IDLE) && req;
  assign acc_wr   = accept && we;
  assign acc_rd   = accept && !we;

`ifdef RAM_PARITY_EN
  assign init_word  = {par_f(PAR_MAX_W'(INIT_VALUE)), INIT_VALUE};
  assign wr_word    = {par_f(PAR_MAX_W'(wdata)) ^ perr_inj, wdata};
  assign parity_err = rvalid_reg && !zero_reg &&
                      (mem_rdata[DATA_W] != par_f(PAR_MAX_W'(mem_rdata[DATA_W-1:0])));
`else
  logic unused_perr_inj;
  assign unused_perr_inj = perr_inj;
  assign init_word  = INIT_VALUE;
  assign wr_word    = wdata;
  assign parity_err = 1'b0;
`endif

  // The next state is computed from state_reg, so an access accepted at the
  // same edge as clr still executes before the sweep starts.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_CLEAR: begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (cnt_reg == CNT_W'(DEPTH - 1)) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        if (clr) begin
          state_next = ST_CLEAR;
          cnt_next   = '0;
        end
      end
    endcase
  end

  // The sweep owns the write port while it runs. In idle, writes to
  // addresses >= DEPTH are dropped here.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = wr_word;
    if (state_reg == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_reg[ADDR_W-1:0];
      mem_wdata = init_word;
    end else begin
      mem_we    = acc_wr && in_range;
    end
  end

  assign mem_re = acc_rd && in_range;

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state_reg  <= ST_CLEAR;
      cnt_reg    <= '0;
      rvalid_reg <= 1'b0;
      zero_reg   <= 1'b1;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      rvalid_reg <= acc_rd;
      if (acc_rd) begin
        zero_reg <= !in_range;
      end
    end
  end

  ram_sweep_array #(
    .W     (MEM_W),
    .AW    (ADDR_W),
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (mem_re),
    .raddr (addr),
    .rdata (mem_rdata)
  );

  assign busy   = (state_reg == ST_CLEAR);
  assign ready  = !busy;
  assign rvalid = rvalid_reg;
  assign rdata  = zero_reg ? '0 : mem_rdata[DATA_W-1:0];

endmodule
